dcache_wb: RTL and testbench

DCACHE_WB -- requirements
Module: dcache_wb

---
 rtl/dcache_wb.sv | 205 ++++++++++++++++++++
 tb/tb_dcache_wb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 128 bits in front of a block memory.
// Optional hit/miss counters are compiled in when DCACHE_PERF_CNT_EN is defined.
module dcache_wb #(
    parameter int LINES = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [127:0]       data_r [LINES];
    logic [24:0]        tags_r [LINES];
    logic [LINES-1:0]   valid_r;
    logic [LINES-1:0]   dirty_r;

    logic [24:0]        tag_s;
    logic [IDX_W-1:0]   idx_s;
    logic [1:0]         off_s;
    logic               req_s;
    logic               hit_s;
    logic [127:0]       line_s;
    logic               rd_hit_s;
    logic               wr_hit_s;
    logic               fill_s;
    logic               miss_s;

    function automatic logic [31:0] get_word(input logic [127:0] line, input logic [1:0] off);
        logic [31:0] w;
        case (off)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            2'd3:    w = line[127:96];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] line, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [127:0] r;
        r = line;
        case (off)
            2'd0:    r[31:0]   = w;
            2'd1:    r[63:32]  = w;
            2'd2:    r[95:64]  = w;
            2'd3:    r[127:96] = w;
            default: r = line;
        endcase
        return r;
    endfunction

    assign tag_s  = proc_addr[29:5];
    assign idx_s  = proc_addr[4:2];
    assign off_s  = proc_addr[1:0];
    assign req_s  = proc_read | proc_write;
    assign line_s = data_r[idx_s];
    assign hit_s  = valid_r[idx_s] & (tags_r[idx_s] == tag_s);

    // Next-state and output decode; reset forces every output to its idle value.
    always_comb begin
        state_nx_s = state_r;
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 28'd0;
        mem_wdata  = 128'd0;
        rd_hit_s   = 1'b0;
        wr_hit_s   = 1'b0;
        fill_s     = 1'b0;
        miss_s     = 1'b0;
        if (proc_reset) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && hit_s) begin
                        // a simultaneous read and write is handled as a write
                        if (proc_write) begin
                            wr_hit_s = 1'b1;
                        end else begin
                            rd_hit_s   = 1'b1;
                            proc_rdata = get_word(line_s, off_s);
                        end
                    end else if (req_s) begin
                        proc_stall = 1'b1;
                        miss_s     = 1'b1;
                        if (valid_r[idx_s] && dirty_r[idx_s]) begin
                            state_nx_s = WRITEBACK;
                        end else begin
                            state_nx_s = ALLOCATE;
                        end
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                WRITEBACK: begin
                    proc_stall = 1'b1;
                    mem_write  = 1'b1;
                    mem_addr   = {tags_r[idx_s], idx_s};
                    mem_wdata  = line_s;
                    if (mem_ready) begin
                        state_nx_s = ALLOCATE;
                    end else begin
                        state_nx_s = WRITEBACK;
                    end
                end
                ALLOCATE: begin
                    proc_stall = 1'b1;
                    mem_read   = 1'b1;
                    mem_addr   = {tag_s, idx_s};
                    if (mem_ready) begin
                        fill_s     = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = ALLOCATE;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State register and per-line valid/dirty bits.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_r <= IDLE;
            valid_r <= '0;
            dirty_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (fill_s) begin
                valid_r[idx_s] <= 1'b1;
                dirty_r[idx_s] <= 1'b0;
            end else if (wr_hit_s) begin
                dirty_r[idx_s] <= 1'b1;
            end
        end
    end

    // Data and tag arrays carry no reset; fill and write-hit strobes are already suppressed by reset.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            data_r[idx_s] <= mem_rdata;
            tags_r[idx_s] <= tag_s;
        end else if (wr_hit_s) begin
            data_r[idx_s] <= put_word(line_s, off_s, proc_wdata);
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic refill_r;
    logic first_hit_s;

    // The request replayed right after a fill is not a hit of its own.
    assign first_hit_s = (rd_hit_s | wr_hit_s) & ~refill_r;

    // Hit and miss counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            refill_r <= 1'b0;
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            refill_r <= fill_s;
            if (first_hit_s) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_s) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: misses with and without writeback, hits, reset abort, stray mem_ready.
module tb_dcache_wb;

    logic         clk;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    int           res_stalls;
    logic         res_saw_wr;
    logic         res_saw_rd;
    logic         res_overlap;
    logic         res_timeout;
    logic [27:0]  res_wr_addr;
    logic [27:0]  res_rd_addr;
    logic [127:0] res_wr_data;
    logic [31:0]  res_rdata;

    dcache_wb dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request (called at posedge+1) and plays a memory with 'lat' cycles latency.
    task access(input logic rd, input logic wr, input logic [29:0] addr, input logic [31:0] wdata,
                input int lat);
        int wcnt;
        int rcnt;
        logic done;
        res_stalls  = 0;
        res_saw_wr  = 1'b0;
        res_saw_rd  = 1'b0;
        res_overlap = 1'b0;
        res_timeout = 1'b0;
        res_wr_addr = 28'd0;
        res_rd_addr = 28'd0;
        res_wr_data = 128'd0;
        res_rdata   = 32'd0;
        wcnt = 0;
        rcnt = 0;
        done = 1'b0;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wdata;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (mem_read && mem_write) res_overlap = 1'b1;
            if (!proc_stall) begin
                res_rdata = proc_rdata;
                done = 1'b1;
            end else begin
                res_stalls++;
                if (mem_write) begin
                    res_saw_wr  = 1'b1;
                    res_wr_addr = mem_addr;
                    res_wr_data = mem_wdata;
                    wcnt++;
                    if (wcnt == lat) mem_ready = 1'b1;
                end
                if (mem_read) begin
                    res_saw_rd  = 1'b1;
                    res_rd_addr = mem_addr;
                    rcnt++;
                    if (rcnt == lat) begin
                        mem_rdata = {4'h3, mem_addr, 4'h2, mem_addr, 4'h1, mem_addr, 4'h0, mem_addr};
                        mem_ready = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
        end
        proc_read  = 1'b0;
        proc_write = 1'b0;
        if (!done) res_timeout = 1'b1;
    endtask

    initial begin
        proc_reset = 1'b1;
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h4;
        proc_wdata = 32'd0;
        mem_rdata  = 128'd0;
        mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_stall", {127'd0, proc_stall}, 128'd0);
        chk("reset_mem_rw", {126'd0, mem_read, mem_write}, 128'd0);
        chk("reset_rdata", {96'd0, proc_rdata}, 128'd0);
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        @(posedge clk);
        #1;

        // cold read miss on 0x4
        access(1'b1, 1'b0, 30'h4, 32'd0, 4);
        chk("r4_timeout", {127'd0, res_timeout}, 128'd0);
        chk("r4_stalls", 128'(res_stalls), 128'd5);
        chk("r4_rdata", {96'd0, res_rdata}, 128'h0000_0001);
        chk("r4_no_wb", {127'd0, res_saw_wr}, 128'd0);
        chk("r4_fill_addr", {100'd0, res_rd_addr}, 128'h1);

        // write hit then read back
        access(1'b0, 1'b1, 30'h4, 32'hDEAD_BEEF, 4);
        chk("w4_stalls", 128'(res_stalls), 128'd0);
        access(1'b1, 1'b0, 30'h4, 32'd0, 4);
        chk("r4b_stalls", 128'(res_stalls), 128'd0);
        chk("r4b_rdata", {96'd0, res_rdata}, 128'hDEAD_BEEF);

        // conflict miss on 0x24 evicts dirty line 1
        access(1'b1, 1'b0, 30'h24, 32'd0, 4);
        chk("r24_timeout", {127'd0, res_timeout}, 128'd0);
        chk("r24_stalls", 128'(res_stalls), 128'd9);
        chk("r24_wb_seen", {127'd0, res_saw_wr}, 128'd1);
        chk("r24_wb_addr", {100'd0, res_wr_addr}, 128'h1);
        chk("r24_wb_data", res_wr_data, {32'h3000_0001, 32'h2000_0001, 32'h1000_0001, 32'hDEAD_BEEF});
        chk("r24_fill_addr", {100'd0, res_rd_addr}, 128'h9);
        chk("r24_overlap", {127'd0, res_overlap}, 128'd0);
        chk("r24_rdata", {96'd0, res_rdata}, 128'h0000_0009);
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt", {96'd0, hit_cnt}, 128'd2);
        chk("miss_cnt", {96'd0, miss_cnt}, 128'd2);
`endif

        // read and write together act as a write
        access(1'b1, 1'b1, 30'h25, 32'hCAFE_0123, 4);
        chk("rw25_stalls", 128'(res_stalls), 128'd0);
        access(1'b1, 1'b0, 30'h25, 32'd0, 4);
        chk("r25_rdata", {96'd0, res_rdata}, 128'hCAFE_0123);

        // write miss allocates, then merges the word
        access(1'b0, 1'b1, 30'h6E, 32'h1234_5678, 1);
        chk("w6e_stalls", 128'(res_stalls), 128'd2);
        chk("w6e_fill_addr", {100'd0, res_rd_addr}, 128'h1B);
        access(1'b1, 1'b0, 30'h6C, 32'd0, 1);
        chk("r6c_rdata", {96'd0, res_rdata}, 128'h0000_001B);
        access(1'b1, 1'b0, 30'h6E, 32'd0, 1);
        chk("r6e_rdata", {96'd0, res_rdata}, 128'h1234_5678);

        // stray mem_ready while idle
        mem_ready = 1'b1;
        #1;
        chk("stray_mem_rw", {126'd0, mem_read, mem_write}, 128'd0);
        chk("stray_stall", {127'd0, proc_stall}, 128'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #1;
        chk("stray_after_rw", {126'd0, mem_read, mem_write}, 128'd0);
        access(1'b1, 1'b0, 30'h24, 32'd0, 1);
        chk("stray_r24_stalls", 128'(res_stalls), 128'd0);
        chk("stray_r24_rdata", {96'd0, res_rdata}, 128'h0000_0009);

        // reset pulse in the middle of an allocate
        proc_read = 1'b1;
        proc_addr = 30'h48;
        #1;
        chk("r48_miss_stall", {127'd0, proc_stall}, 128'd1);
        @(posedge clk);
        #1;
        chk("r48_alloc_read", {127'd0, mem_read}, 128'd1);
        chk("r48_alloc_addr", {100'd0, mem_addr}, 128'h12);
        proc_reset = 1'b1;
        #1;
        chk("abort_mem_read", {127'd0, mem_read}, 128'd0);
        chk("abort_stall", {127'd0, proc_stall}, 128'd0);
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        access(1'b1, 1'b0, 30'h48, 32'd0, 2);
        chk("r48_again_stalls", 128'(res_stalls), 128'd3);
        chk("r48_again_rdata", {96'd0, res_rdata}, 128'h0000_0012);
        access(1'b1, 1'b0, 30'h24, 32'd0, 2);
        chk("r24_post_reset_stalls", 128'(res_stalls), 128'd3);
        chk("r24_post_reset_no_wb", {127'd0, res_saw_wr}, 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
